song_sequencer: RTL
===================

# song_sequencer

Auto-play scheduler for the mini piano. It walks a per-song note table and drives the buzzer's `note`/`octave` inputs and the note LEDs while auto mode is selected. It sits between the mode/song-select logic and the Buzzer datapath, and sequences note, duration and inter-note gap. It also handles next/previous song selection and pause.

## Interface
Parameters:
- `BEAT_CYCLES`, default 25_000_000: clocks per duration unit (0.25 s at 100 MHz).
- `GAP_CYCLES`, default 2_500_000: silent clocks between consecutive notes.
- `NUM_SONGS`, default 4: songs in the table, power of two.
- `SONG_LEN`, default 32: max entries per song, power of two.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: auto mode selected (`mode == 3'b010`), level.
- `song_next` input 1: single-cycle pulse, advance song.
- `song_prev` input 1: single-cycle pulse, previous song.
- `pause` input 1: level; high freezes playback.
- `note_out` output 4: 0 = silence, 1–7 = do..si, to Buzzer.
- `octave_out` output 2: octave of current note, to Buzzer.
- `led_out` output 7: one-hot `led_out[note_out-1]`; all zero on silence.
- `song_idx` output log2(NUM_SONGS): currently selected song.
- `playing` output 1: high in PLAY and GAP.
- `done` output 1: one-cycle pulse on entering END.

## Operation
- **Table entry (9 bits):** `note[8:5]`, `dur[4:2]`, `oct[1:0]`.
  - note 0 = rest, which still occupies `dur`.
  - note 4'hF = end marker.
  - dur 0 is treated as 1.
- **FSM states:** IDLE, FETCH, PLAY, GAP, END. Reset state is IDLE.
- **IDLE:** outputs silent. `enable`=1 → FETCH with index 0.
- **FETCH:** one cycle of ROM latency. The next cycle registers the entry:
  - end marker, or index == SONG_LEN → END;
  - otherwise → PLAY, load `note_out`/`octave_out`, counter = `dur`×`BEAT_CYCLES`−1.
- **PLAY:** counter decrements to 0 → GAP, note_out=0, counter = `GAP_CYCLES`−1.
- **GAP:** counter reaches 0 → index+1 → FETCH.
- **END:** silent, `done` pulses on entry. END is held until `enable` falls (→ IDLE) or a song change occurs.
- **`enable`=0 in any state:** IDLE on the next cycle, outputs silent, index 0. `song_idx` is kept.
- **`pause`=1 in PLAY/GAP:** counter and index frozen, note_out=0, LEDs off, `playing` stays 1. On release, the stored note is restored and the count resumes where it stopped. `pause` has no effect in other states.
- **Song change:**
  - `song_next` → `song_idx`+1 mod NUM_SONGS; `song_prev` → `song_idx`−1 mod NUM_SONGS. Both wrap.
  - index → 0, counters cleared.
  - Next state is FETCH if `enable`, else IDLE.
  - Song change overrides pause. It is accepted in every state, including mid-note.
- **Simultaneous `song_next` and `song_prev`:** both ignored.
- **Priority:** reset > `enable`=0 > song change > pause > normal sequencing.
- **Counter width:** counters are ceil(log2(7×`BEAT_CYCLES`)) bits. The product is computed at elaboration; no runtime multiply.

## Timing
- **Reset values:** `note_out`=0, `octave_out`=0, `led_out`=0, `song_idx`=0, `playing`=0, `done`=0, index 0, state IDLE.
- **Output registration:** all outputs are registered.
- **Start latency:** with `enable` rising at cycle 0, the FSM is in FETCH at cycle 1 and the first note is on `note_out` at cycle 2.
- **Cycles per non-final entry:** 1 (FETCH) + `dur`×`BEAT_CYCLES` (PLAY) + `GAP_CYCLES` (GAP).
- **Pause:** takes effect on outputs one cycle after assertion. Release restores the note one cycle after deassertion.
- **Song change:** `song_idx` updates the cycle after the pulse. The new song's first note appears 2 cycles after the pulse.

## Structure
- **Shared package `piano_pkg`:**
  - note constants NOTE_REST=0, NOTE_DO..NOTE_SI=1..7, NOTE_END=4'hF;
  - the entry field positions;
  - the FSM state enum.
- **Sub-module `song_rom`:** synchronous-read table, address {`song_idx`, index}. It is kept separate so song content changes do not touch the FSM.
- **LED decode:** an inline function in the package. The Controller reuses it for free/learn modes.

## Test plan
Use `BEAT_CYCLES`=4 and `GAP_CYCLES`=2.
1. **Basic playback:** song 0 = {do,dur1},{mi,dur2},END; `enable` high at cycle 0.
   - `note_out`=1 on cycles 2–5, 0 on 6–7, 3 on 9–16;
   - `done` pulses once, then silent.
2. **Reset mid-note:** `reset` low during PLAY → all outputs 0 immediately (async); IDLE after release.
3. **Pause and resume:** pause for 10 cycles after 2 cycles of a dur=1 note → `note_out`=0 while paused; the note resumes for exactly 2 more cycles.
4. **Song wrap:** `song_prev` at `song_idx`=0 → `song_idx`=3 and the first note of song 3 appears 2 cycles later. `song_next` at 3 → 0.
5. **Simultaneous select:** `song_next` and `song_prev` in the same cycle → `song_idx` and playback unchanged.
6. **Disable and edge entries:**
   - `enable` dropped mid-GAP → IDLE next cycle, outputs 0;
   - re-enable → restart at index 0;
   - a dur=0 entry plays 4 cycles;
   - a full 32-entry song with no marker reaches END.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared mini-piano definitions: note codes, song-table entry layout, sequencer states
// and the note-to-LED decode used by both the sequencer and the controller.
package piano_pkg;

  localparam int unsigned ENTRY_W = 9;
  localparam int unsigned NOTE_HI = 8;
  localparam int unsigned NOTE_LO = 5;
  localparam int unsigned DUR_HI  = 4;
  localparam int unsigned DUR_LO  = 2;
  localparam int unsigned OCT_HI  = 1;
  localparam int unsigned OCT_LO  = 0;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;
  localparam logic [3:0] NOTE_END  = 4'hF;

  localparam logic [ENTRY_W-1:0] END_ENTRY = {NOTE_END, 5'b0_0000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP,
    ST_END
  } seq_state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [3:0] note,
                                                    input logic [2:0] dur,
                                                    input logic [1:0] oct);
    return {note, dur, oct};
  endfunction

  // One-hot LED for do..si; rest, end marker and unused codes light nothing.
  function automatic logic [6:0] led_decode(input logic [3:0] note);
    logic [6:0] leds;
    leds = '0;
    if (note >= NOTE_DO && note <= NOTE_SI) leds = 7'b000_0001 << (note - 4'd1);
    return leds;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song table addressed by {song, index}; song content lives only here.
module song_rom
  import piano_pkg::*;
#(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned SONG_LEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_SONGS)-1:0] song,
  input  logic [$clog2(SONG_LEN)-1:0]  idx,
  output logic [ENTRY_W-1:0]           data
);

  localparam int unsigned IDX_W = $clog2(SONG_LEN);

  // Song 2 fills every slot with no end marker so the length limit terminates it.
  function automatic logic [ENTRY_W-1:0] table_entry(input logic [1:0] s,
                                                     input logic [IDX_W-1:0] i);
    logic [ENTRY_W-1:0] e;
    e = END_ENTRY;
    case (s)
      2'd0: begin
        case (32'(i))
          0:       e = make_entry(NOTE_DO, 3'd1, 2'd1);
          1:       e = make_entry(NOTE_MI, 3'd2, 2'd1);
          default: e = END_ENTRY;
        endcase
      end
      2'd1: begin
        case (32'(i))
          0:       e = make_entry(NOTE_SOL, 3'd0, 2'd2);
          1:       e = make_entry(NOTE_REST, 3'd1, 2'd0);
          2:       e = make_entry(NOTE_LA, 3'd1, 2'd2);
          default: e = END_ENTRY;
        endcase
      end
      2'd2: e = make_entry(4'(32'(i) % 32'd7 + 32'd1), 3'd1, 2'(i));
      default: begin
        case (32'(i))
          0:       e = make_entry(NOTE_SI, 3'd1, 2'd3);
          1:       e = make_entry(NOTE_DO, 3'd2, 2'd0);
          default: e = END_ENTRY;
        endcase
      end
    endcase
    return e;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data <= '0;
    else        data <= table_entry(2'(song), idx);
  end

endmodule

// File: rtl/song_sequencer.sv
// Auto-play scheduler: walks the selected song's table and drives note/octave/LEDs,
// sequencing note duration, inter-note gap, pause and next/previous song selection.
module song_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned NUM_SONGS   = 4,
  parameter int unsigned SONG_LEN    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         song_next,
  input  logic                         song_prev,
  input  logic                         pause,
  output logic [3:0]                   note_out,
  output logic [1:0]                   octave_out,
  output logic [6:0]                   led_out,
  output logic [$clog2(NUM_SONGS)-1:0] song_idx,
  output logic                         playing,
  output logic                         done
);

  localparam int unsigned SONG_W = $clog2(NUM_SONGS);
  localparam int unsigned IDX_W  = $clog2(SONG_LEN);
  localparam int unsigned POS_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(7 * BEAT_CYCLES);

  seq_state_t          state;
  logic [POS_W-1:0]    pos;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          cur_note;
  logic [1:0]          cur_oct;
  logic [ENTRY_W-1:0]  entry;
  logic                chg_c;
  logic [SONG_W-1:0]   song_new_c;
  logic [SONG_W-1:0]   rd_song_c;
  logic [IDX_W-1:0]    rd_idx_c;

  // Duration loads are elaboration-time constants, so no runtime multiplier.
  function automatic logic [CNT_W-1:0] play_load(input logic [2:0] dur);
    logic [CNT_W-1:0] v;
    case (dur)
      3'd2:    v = CNT_W'(2 * BEAT_CYCLES - 1);
      3'd3:    v = CNT_W'(3 * BEAT_CYCLES - 1);
      3'd4:    v = CNT_W'(4 * BEAT_CYCLES - 1);
      3'd5:    v = CNT_W'(5 * BEAT_CYCLES - 1);
      3'd6:    v = CNT_W'(6 * BEAT_CYCLES - 1);
      3'd7:    v = CNT_W'(7 * BEAT_CYCLES - 1);
      default: v = CNT_W'(BEAT_CYCLES - 1);
    endcase
    return v;
  endfunction

  assign chg_c      = song_next ^ song_prev;
  assign song_new_c = song_next ? song_idx + SONG_W'(1) : song_idx - SONG_W'(1);

  // Present the address of the entry FETCH will consume one cycle ahead, hiding ROM latency.
  always_comb begin
    rd_song_c = song_idx;
    rd_idx_c  = pos[IDX_W-1:0];
    if (chg_c) begin
      rd_song_c = song_new_c;
      rd_idx_c  = '0;
    end else if (state == ST_GAP) begin
      rd_idx_c = pos[IDX_W-1:0] + IDX_W'(1);
    end
  end

  song_rom #(
    .NUM_SONGS (NUM_SONGS),
    .SONG_LEN  (SONG_LEN)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .song  (rd_song_c),
    .idx   (rd_idx_c),
    .data  (entry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pos        <= '0;
      cnt        <= '0;
      cur_note   <= NOTE_REST;
      cur_oct    <= '0;
      note_out   <= NOTE_REST;
      octave_out <= '0;
      led_out    <= '0;
      song_idx   <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (chg_c) song_idx <= song_new_c;
      if (!enable || chg_c) begin
        state      <= enable ? ST_FETCH : ST_IDLE;
        pos        <= '0;
        cnt        <= '0;
        note_out   <= NOTE_REST;
        octave_out <= '0;
        led_out    <= '0;
        playing    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_FETCH;
            pos   <= '0;
          end
          ST_FETCH: begin
            if (pos == POS_W'(SONG_LEN) || entry[NOTE_HI:NOTE_LO] == NOTE_END) begin
              state <= ST_END;
              done  <= 1'b1;
            end else begin
              state      <= ST_PLAY;
              cur_note   <= entry[NOTE_HI:NOTE_LO];
              cur_oct    <= entry[OCT_HI:OCT_LO];
              note_out   <= entry[NOTE_HI:NOTE_LO];
              octave_out <= entry[OCT_HI:OCT_LO];
              led_out    <= led_decode(entry[NOTE_HI:NOTE_LO]);
              cnt        <= play_load(entry[DUR_HI:DUR_LO]);
              playing    <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (pause) begin
              note_out   <= NOTE_REST;
              octave_out <= '0;
              led_out    <= '0;
            end else if (cnt == '0) begin
              state      <= ST_GAP;
              cnt        <= CNT_W'(GAP_CYCLES - 1);
              note_out   <= NOTE_REST;
              octave_out <= '0;
              led_out    <= '0;
            end else begin
              cnt        <= cnt - CNT_W'(1);
              note_out   <= cur_note;
              octave_out <= cur_oct;
              led_out    <= led_decode(cur_note);
            end
          end
          ST_GAP: begin
            if (!pause) begin
              if (cnt == '0) begin
                state   <= ST_FETCH;
                pos     <= pos + POS_W'(1);
                playing <= 1'b0;
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          ST_END: begin
            state <= ST_END;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
